// File: rtl/pipe_seq.sv
// rtl/pipe_seq.sv - stall/flush sequencer for the 5-stage core pipeline
// Mealy control outputs from state/cnt/inputs; multi-cycle hazards held in HOLD.
module pipe_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       stall_c,
  input  logic             br_taken,
  input  logic             halt_id,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_bubble,
  output logic             ex_mem_we,
  output logic             mem_wb_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, HOLD, HALTED} state_t;

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       freeze;

  always_comb begin
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_we      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_we     = 1'b1;
    mem_wb_bubble = 1'b0;
    halted        = 1'b0;
    state_nxt     = state;
    cnt_nxt       = cnt;
    freeze        = 1'b0;

    if (state == HALTED) begin
      halted = 1'b1;
      if (dmem_stall) begin
        freeze = 1'b1;
      end else begin
        pc_we       = 1'b0;
        if_id_flush = 1'b1;
      end
    end else if (dmem_stall) begin
      freeze = 1'b1;
    end else if (br_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_nxt    = RUN;
      cnt_nxt      = 2'd0;
    end else if (state == HOLD || stall_c != 2'd0) begin
      // IF/ID is held, not flushed, so an overlapping I-miss simply retries
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
      if (state == HOLD) begin
        cnt_nxt = cnt - 2'd1;
        if (cnt <= 2'd1) state_nxt = RUN;
      end else if (stall_c != 2'd1) begin
        state_nxt = HOLD;
        cnt_nxt   = stall_c - 2'd1;
      end
    end else if (halt_id) begin
      pc_we       = 1'b0;
      if_id_flush = 1'b1;
      state_nxt   = HALTED;
    end else if (imem_stall) begin
      pc_we       = 1'b0;
      if_id_flush = 1'b1;
    end

    if (freeze) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_we      = 1'b0;
      id_ex_bubble  = 1'b0;
      ex_mem_we     = 1'b0;
      mem_wb_bubble = 1'b1;
    end

    if (rst) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_we     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      mem_wb_bubble = 1'b1;
      halted        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      cnt          <= 2'd0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!pc_we && state != HALTED && stall_cycles != {CNT_W{1'b1}})
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_seq.sv
// tb/tb_pipe_seq.sv - directed self-checking bench for pipe_seq
// A second instance with a 2-bit counter exercises saturation.
module tb_pipe_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  stall_c;
  logic        br_taken, halt_id, imem_stall, dmem_stall;
  logic        pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble, halted;
  logic [15:0] stall_cycles;
  logic        s_pc_we, s_if_id_we, s_if_id_flush, s_id_ex_we, s_id_ex_bubble, s_ex_mem_we, s_mem_wb_bubble, s_halted;
  logic [1:0]  s_stall_cycles;

  int errors = 0;
  int checks = 0;

  // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble}
  localparam logic [6:0] C_DEF = 7'b1101010;
  localparam logic [6:0] C_HAZ = 7'b0001110;
  localparam logic [6:0] C_FRZ = 7'b0000001;
  localparam logic [6:0] C_BR  = 7'b1111110;
  localparam logic [6:0] C_HLT = 7'b0111010;
  localparam logic [6:0] C_RST = 7'b0010101;

  logic [6:0] ctl;
  assign ctl = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble};

  always #5 clk = ~clk;

  pipe_seq #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall_c(stall_c), .br_taken(br_taken), .halt_id(halt_id),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall), .pc_we(pc_we), .if_id_we(if_id_we),
    .if_id_flush(if_id_flush), .id_ex_we(id_ex_we), .id_ex_bubble(id_ex_bubble),
    .ex_mem_we(ex_mem_we), .mem_wb_bubble(mem_wb_bubble), .halted(halted),
    .stall_cycles(stall_cycles)
  );

  pipe_seq #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .stall_c(stall_c), .br_taken(br_taken), .halt_id(halt_id),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall), .pc_we(s_pc_we), .if_id_we(s_if_id_we),
    .if_id_flush(s_if_id_flush), .id_ex_we(s_id_ex_we), .id_ex_bubble(s_id_ex_bubble),
    .ex_mem_we(s_ex_mem_we), .mem_wb_bubble(s_mem_wb_bubble), .halted(s_halted),
    .stall_cycles(s_stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] sc, input logic br, input logic hl,
                     input logic im, input logic dm);
    @(negedge clk);
    stall_c = sc; br_taken = br; halt_id = hl; imem_stall = im; dmem_stall = dm;
    #1;
  endtask

  initial begin
    rst = 1'b1; stall_c = 2'd0; br_taken = 1'b0; halt_id = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0;
    cyc(2'd0, 0, 0, 0, 0);
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rst_halted", 32'(halted), 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("idle_ctl", 32'(ctl), 32'(C_DEF));
    chk("idle_cnt", 32'(stall_cycles), 0);

    // load-use, one bubble
    cyc(2'd1, 0, 0, 0, 0); chk("lu_haz", 32'(ctl), 32'(C_HAZ));
    cyc(2'd0, 0, 0, 0, 0); chk("lu_def", 32'(ctl), 32'(C_DEF));
    chk("lu_cnt", 32'(stall_cycles), 1);

    // two bubbles via HOLD
    cyc(2'd2, 0, 0, 0, 0); chk("b2_haz1", 32'(ctl), 32'(C_HAZ));
    cyc(2'd0, 0, 0, 0, 0); chk("b2_haz2", 32'(ctl), 32'(C_HAZ));
    cyc(2'd0, 0, 0, 0, 0); chk("b2_def", 32'(ctl), 32'(C_DEF));
    chk("b2_cnt", 32'(stall_cycles), 3);

    // three bubbles with a 3-cycle D-cache freeze inside
    cyc(2'd3, 0, 0, 0, 0); chk("b3_haz1", 32'(ctl), 32'(C_HAZ));
    for (int i = 0; i < 3; i++) begin
      cyc(2'd0, 0, 0, 0, 1); chk("b3_frz", 32'(ctl), 32'(C_FRZ));
    end
    cyc(2'd1, 0, 0, 0, 0); chk("b3_haz2", 32'(ctl), 32'(C_HAZ));
    cyc(2'd0, 0, 0, 0, 0); chk("b3_haz3", 32'(ctl), 32'(C_HAZ));
    cyc(2'd0, 0, 0, 0, 0); chk("b3_def", 32'(ctl), 32'(C_DEF));
    chk("b3_cnt", 32'(stall_cycles), 9);

    // branch cancels HOLD
    cyc(2'd2, 0, 0, 0, 0); chk("br_haz", 32'(ctl), 32'(C_HAZ));
    cyc(2'd0, 1, 0, 0, 0); chk("br_flush", 32'(ctl), 32'(C_BR));
    cyc(2'd0, 0, 0, 0, 0); chk("br_def", 32'(ctl), 32'(C_DEF));
    chk("br_cnt", 32'(stall_cycles), 10);

    // I-miss overlapping a hazard, then alone
    cyc(2'd1, 0, 0, 1, 0); chk("im_haz", 32'(ctl), 32'(C_HAZ));
    cyc(2'd0, 0, 0, 1, 0); chk("im_only", 32'(ctl), 32'(C_HLT));
    cyc(2'd0, 0, 0, 0, 0); chk("im_def", 32'(ctl), 32'(C_DEF));
    chk("im_cnt", 32'(stall_cycles), 12);

    // halt ignored in HOLD, taken in RUN
    cyc(2'd2, 0, 0, 0, 0); chk("hh_haz1", 32'(ctl), 32'(C_HAZ));
    cyc(2'd0, 0, 1, 0, 0); chk("hh_haz2", 32'(ctl), 32'(C_HAZ));
    cyc(2'd0, 0, 1, 0, 0); chk("halt_ctl", 32'(ctl), 32'(C_HLT));
    chk("halt_pre", 32'(halted), 0);
    chk("halt_cnt0", 32'(stall_cycles), 14);
    cyc(2'd1, 1, 0, 0, 0); chk("hlt_br", 32'(ctl), 32'(C_HLT));
    chk("hlt_flag", 32'(halted), 1);
    chk("hlt_cnt1", 32'(stall_cycles), 15);
    cyc(2'd0, 0, 0, 1, 0); chk("hlt_im", 32'(ctl), 32'(C_HLT));
    cyc(2'd0, 0, 0, 0, 1);
    chk("hlt_dm_pc", 32'(pc_we), 0);
    chk("hlt_dm_ex", 32'(ex_mem_we), 0);
    chk("hlt_dm_wb", 32'(mem_wb_bubble), 1);
    cyc(2'd0, 0, 0, 0, 0);
    chk("hlt_cnt2", 32'(stall_cycles), 15);
    chk("sat_cnt", 32'(s_stall_cycles), 3);

    // reset out of HALTED
    @(negedge clk); rst = 1'b1; #1;
    chk("rst2_ctl", 32'(ctl), 32'(C_RST));
    chk("rst2_halted", 32'(halted), 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_halted", 32'(halted), 0);
    chk("post_cnt", 32'(stall_cycles), 0);
    chk("post_ctl", 32'(ctl), 32'(C_DEF));
    cyc(2'd1, 0, 0, 0, 0); chk("post_haz", 32'(ctl), 32'(C_HAZ));
    cyc(2'd0, 0, 0, 0, 0); chk("post_cnt1", 32'(stall_cycles), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
